// File: rtl/m_alu_digser.sv
// Digit-serial midgetv ALU: LSB digit first, carry held between digits.
// Define ALU_ZEROFLAG_EN to add the alu_zero result flag.
module m_alu_digser #(
  parameter int ALUWIDTH     = 32,
  parameter int DIGITWIDTH   = 8,
  parameter int MTIMETAP     = 0,
  parameter int SRAMADRWIDTH = 0
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                start,
  input  logic [ALUWIDTH-1:0] Di,
  input  logic [ALUWIDTH-1:0] ADR_O,
  input  logic [ALUWIDTH-1:0] QQ,
  input  logic                alu_carryin,
  input  logic                sa06,
  input  logic                sa05,
  input  logic                sa04,
  input  logic                sa27,
  input  logic                sa26,
  input  logic                sa25,
  input  logic                sa24,
  output logic                busy,
  output logic                done,
  output logic [ALUWIDTH-1:0] B,
  output logic                alu_carryout,
  output logic                alu_tapout,
  output logic                alu_minstretofl
`ifdef ALU_ZEROFLAG_EN
  ,
  output logic                alu_zero
`endif
);

  localparam int N  = ALUWIDTH / DIGITWIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TAP =
    (MTIMETAP >= ALUWIDTH) ? ALUWIDTH - 1 : MTIMETAP;
  localparam bit TAP_EN = (MTIMETAP > 13);
  localparam bit OFL_EN = TAP_EN && (SRAMADRWIDTH != 0);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cy_q, cy_d;
  logic [ALUWIDTH-1:0] di_q, di_d;
  logic [ALUWIDTH-1:0] q_q, q_d;
  logic [ALUWIDTH-1:0] qq_q, qq_d;
  logic [2:0]          op_q, op_d;
  logic                wtt_q, wtt_d;
  logic                wri_q, wri_d;
  logic [ALUWIDTH-1:0] b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cout_q, cout_d;
  logic                tap_q, tap_d;
  logic                ofl_q, ofl_d;
  logic                zacc_q, zacc_d;
  logic                zero_q, zero_d;

  logic [ALUWIDTH-1:0]   a_full;
  logic [ALUWIDTH-1:0]   b_upd;
  logic [DIGITWIDTH-1:0] a_dig;
  logic [DIGITWIDTH-1:0] qq_dig;
  logic [DIGITWIDTH-1:0] r_dig;
  logic [DIGITWIDTH:0]   sum;
  logic                  accept;
  logic                  last;
  int                    base;

  always_comb begin
    a_full = op_q[1]
      ? (op_q[0] ? '0 : (~di_q & ~q_q))
      : (op_q[0] ? ~(di_q ^ q_q) : di_q);
    base   = int'(cnt_q) * DIGITWIDTH;
    a_dig  = a_full[base +: DIGITWIDTH];
    qq_dig = qq_q[base +: DIGITWIDTH];
    // Carry chain runs for every op; only the result mux looks at sa06.
    sum    = {1'b0, a_dig} + {1'b0, qq_dig}
           + {{DIGITWIDTH{1'b0}}, cy_q};
    r_dig  = op_q[2] ? sum[DIGITWIDTH-1:0] : ~(a_dig ^ qq_dig);
    b_upd  = b_q;
    b_upd[base +: DIGITWIDTH] = r_dig;
    accept = start && (state_q != RUN);
    last   = (state_q == RUN) && (cnt_q == LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    di_d    = di_q;
    q_d     = q_q;
    qq_d    = qq_q;
    op_d    = op_q;
    wtt_d   = wtt_q;
    wri_d   = wri_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    tap_d   = 1'b0;
    ofl_d   = 1'b0;
    zacc_d  = zacc_q;
    zero_d  = zero_q;

    if (accept) begin
      di_d    = Di;
      q_d     = ADR_O;
      qq_d    = QQ;
      op_d    = {sa06, sa05, sa04};
      wtt_d   = ({sa27, sa26, sa25, sa24} == 4'b1011);
      wri_d   = ({sa27, sa26, sa25, sa24} == 4'b1001);
      cy_d    = alu_carryin;
      cnt_d   = '0;
      zacc_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          b_d    = b_upd;
          cy_d   = sum[DIGITWIDTH];
          cnt_d  = cnt_q + CW'(1);
          zacc_d = zacc_q | (|r_dig);
          if (last) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cout_d  = sum[DIGITWIDTH];
            tap_d   = TAP_EN & wtt_q
                    & (a_full[TAP] ^ b_upd[TAP]);
            ofl_d   = OFL_EN & wri_q & sum[DIGITWIDTH];
            zero_d  = ~(zacc_q | (|r_dig));
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      di_q    <= '0;
      q_q     <= '0;
      qq_q    <= '0;
      op_q    <= '0;
      wtt_q   <= 1'b0;
      wri_q   <= 1'b0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      tap_q   <= 1'b0;
      ofl_q   <= 1'b0;
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      di_q    <= di_d;
      q_q     <= q_d;
      qq_q    <= qq_d;
      op_q    <= op_d;
      wtt_q   <= wtt_d;
      wri_q   <= wri_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      tap_q   <= tap_d;
      ofl_q   <= ofl_d;
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign B               = b_q;
  assign alu_carryout    = cout_q;
  assign alu_tapout      = tap_q;
  assign alu_minstretofl = ofl_q;
`ifdef ALU_ZEROFLAG_EN
  assign alu_zero        = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zacc_q ^ zero_q;
`endif

endmodule
